// File: rtl/usb_fs_in_arb.sv
// usb_fs_in_arb
//   Round-robin arbiter. It lets NUM_SRC byte-stream sources share the
//   USB full-speed IN endpoint buffers. Source i always loads IN endpoint i.
//   Only one source holds a grant at a time. Its bytes are forwarded to the
//   IN protocol engine one cycle after they are accepted.
//
// Parameters
//   NUM_SRC            number of sources / IN endpoints
//   MAX_IN_PACKET_SIZE bytes after which a packet is closed without a done pulse
//   TIMEOUT_CYCLES     idle-grant limit (only with USB_IN_ARB_TIMEOUT_EN)
//
// Optional feature
//   `define USB_IN_ARB_TIMEOUT_EN enables the idle-grant watchdog.
//   Without it the grant is held indefinitely and timeout_err is tied low.
//
// Ports
//   clk, reset_n         clock (rising edge) / async active-low reset
//   src_req              source i has a packet to load
//   src_put, src_last    byte strobe / final-byte qualifier per source
//   src_data             byte of source i at [8i+7:8i]
//   src_grant            one-hot grant to the sources
//   ep_data_free         endpoint buffer i can take data
//   ep_data_put, ep_data one-hot registered byte strobe and byte to the engine
//   ep_data_done         one-hot packet-done pulse
//   busy                 a grant is active
//   put_err              sticky: a non-granted source strobed a byte
//   timeout_err          sticky: a grant idled out
module usb_fs_in_arb #(
    parameter int NUM_SRC            = 4,
    parameter int MAX_IN_PACKET_SIZE = 32,
    parameter int TIMEOUT_CYCLES     = 255
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_SRC-1:0]   src_req,
    input  logic [NUM_SRC-1:0]   src_put,
    input  logic [8*NUM_SRC-1:0] src_data,
    input  logic [NUM_SRC-1:0]   src_last,
    output logic [NUM_SRC-1:0]   src_grant,
    input  logic [NUM_SRC-1:0]   ep_data_free,
    output logic [NUM_SRC-1:0]   ep_data_put,
    output logic [7:0]           ep_data,
    output logic [NUM_SRC-1:0]   ep_data_done,
    output logic                 busy,
    output logic                 put_err,
    output logic                 timeout_err
);

    localparam int          IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int          CNT_W  = $clog2(MAX_IN_PACKET_SIZE) + 1;
    localparam int unsigned NSRC_U = NUM_SRC;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   cur_q, cur_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [NUM_SRC-1:0] grant_d, put_d, done_d;
    logic [7:0]         data_d;
    logic               perr_d;

    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] cur_oh, pick_oh;
    logic [IDX_W-1:0]   pick, idx;
    logic               found;
    logic               accept;
    logic               full;
    logic [7:0]         src_byte;

`ifdef USB_IN_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] idle_q, idle_d, idle_inc;
    logic            terr_d;
`endif

    assign eligible = src_req & ep_data_free;
    assign cur_oh   = NUM_SRC'(1) << cur_q;
    assign pick_oh  = NUM_SRC'(1) << pick;
    assign accept   = src_put[cur_q] & src_grant[cur_q] & ep_data_free[cur_q];
    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign full     = (cnt_inc == CNT_W'(MAX_IN_PACKET_SIZE));
    // {cur_q, 3'b000} is exactly wide enough to address the packed byte lanes
    assign src_byte = src_data[{cur_q, 3'b000} +: 8];
    assign busy     = (state_q == GRANT);

    // Rotating-priority search: first eligible index after last_q, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int unsigned off = 1; off <= NSRC_U; off++) begin
            idx = IDX_W'((32'(last_q) + off) % NSRC_U);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        grant_d = src_grant;
        put_d   = '0;
        done_d  = '0;
        data_d  = ep_data;
        perr_d  = put_err | (|(src_put & ~src_grant));
`ifdef USB_IN_ARB_TIMEOUT_EN
        idle_d   = idle_q;
        idle_inc = idle_q + TO_W'(1);
        terr_d   = timeout_err;
`endif
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    cur_d   = pick;
                    grant_d = pick_oh;
                    cnt_d   = '0;
`ifdef USB_IN_ARB_TIMEOUT_EN
                    idle_d  = '0;
`endif
                end
            end
            GRANT: begin
                if (accept) begin
                    put_d  = cur_oh;
                    data_d = src_byte;
                    cnt_d  = cnt_inc;
`ifdef USB_IN_ARB_TIMEOUT_EN
                    idle_d = '0;
`endif
                    // A full packet closes silently; src_last alone drives done,
                    // so last-and-full yields a single pulse.
                    if (src_last[cur_q] || full) begin
                        state_d = RELEASE;
                        grant_d = '0;
                        done_d  = src_last[cur_q] ? cur_oh : '0;
                    end
                end else if (!src_req[cur_q]) begin
                    done_d  = cur_oh;
                    state_d = RELEASE;
                    grant_d = '0;
                end
`ifdef USB_IN_ARB_TIMEOUT_EN
                else if (idle_inc == TO_W'(TIMEOUT_CYCLES)) begin
                    done_d  = cur_oh;
                    terr_d  = 1'b1;
                    state_d = RELEASE;
                    grant_d = '0;
                end else begin
                    idle_d = idle_inc;
                end
`endif
            end
            RELEASE: begin
                last_d  = cur_q;
                grant_d = '0;
                state_d = IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cur_q        <= '0;
            last_q       <= IDX_W'(NUM_SRC - 1);
            cnt_q        <= '0;
            src_grant    <= '0;
            ep_data_put  <= '0;
            ep_data      <= '0;
            ep_data_done <= '0;
            put_err      <= 1'b0;
`ifdef USB_IN_ARB_TIMEOUT_EN
            idle_q       <= '0;
            timeout_err  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            src_grant    <= grant_d;
            ep_data_put  <= put_d;
            ep_data      <= data_d;
            ep_data_done <= done_d;
            put_err      <= perr_d;
`ifdef USB_IN_ARB_TIMEOUT_EN
            idle_q       <= idle_d;
            timeout_err  <= terr_d;
`endif
        end
    end

`ifndef USB_IN_ARB_TIMEOUT_EN
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_usb_fs_in_arb.sv
// tb_usb_fs_in_arb
//   Self-checking bench for usb_fs_in_arb (NUM_SRC=4, MAX_IN_PACKET_SIZE=32,
//   TIMEOUT_CYCLES=8). Inputs change on the falling edge and outputs are
//   sampled on the falling edge. Each stimulus is therefore consumed by one
//   rising edge and judged at the following falling edge.
module tb_usb_fs_in_arb;
    localparam int N    = 4;
    localparam int MAXP = 32;
    localparam int TO   = 8;
`ifdef USB_IN_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [3:0]   src_req, src_put, src_last, ep_data_free;
    logic [31:0]  src_data;
    logic [3:0]   src_grant, ep_data_put, ep_data_done;
    logic [7:0]   ep_data;
    logic         busy, put_err, timeout_err;

    int n_pass  = 0;
    int n_total = 0;

    usb_fs_in_arb #(
        .NUM_SRC(N),
        .MAX_IN_PACKET_SIZE(MAXP),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .src_req(src_req),
        .src_put(src_put),
        .src_data(src_data),
        .src_last(src_last),
        .src_grant(src_grant),
        .ep_data_free(ep_data_free),
        .ep_data_put(ep_data_put),
        .ep_data(ep_data),
        .ep_data_done(ep_data_done),
        .busy(busy),
        .put_err(put_err),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- behavioural reference ----------------
    // It tracks who holds the grant (or -1) and whether the one-cycle gap
    // after a packet is under way. The rotation pointer moves when a grant
    // is handed out.
    int         m_owner, m_last, m_bytes, m_idle;
    bit         m_gap;
    logic [3:0] m_grant, m_put, m_done;
    logic [7:0] m_data;
    logic       m_perr, m_terr;

    task automatic model_reset();
        m_owner = -1; m_last = N - 1; m_bytes = 0; m_idle = 0; m_gap = 1'b0;
        m_grant = '0; m_put = '0; m_done = '0; m_data = '0; m_perr = 1'b0; m_terr = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] rq, input logic [3:0] pt, input logic [3:0] ls,
                              input logic [3:0] fr, input logic [31:0] dw);
        int k;
        if ((pt & ~m_grant) != 0) m_perr = 1'b1;
        m_put  = '0;
        m_done = '0;
        if (m_owner >= 0) begin
            k = m_owner;
            if (pt[k] && fr[k]) begin
                m_put   = 4'(1 << k);
                m_data  = dw[8*k +: 8];
                m_bytes = m_bytes + 1;
                m_idle  = 0;
                if (ls[k]) m_done = 4'(1 << k);
                if (ls[k] || m_bytes == MAXP) begin m_owner = -1; m_gap = 1'b1; end
            end else if (!rq[k]) begin
                m_done = 4'(1 << k); m_owner = -1; m_gap = 1'b1;
            end else if (TO_EN) begin
                m_idle = m_idle + 1;
                if (m_idle == TO) begin
                    m_done = 4'(1 << k); m_terr = 1'b1; m_owner = -1; m_gap = 1'b1;
                end
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else begin
            for (int o = 1; o <= N; o++) begin
                k = (m_last + o) % N;
                if (m_owner < 0 && rq[k] && fr[k]) begin
                    m_owner = k; m_last = k; m_bytes = 0; m_idle = 0;
                end
            end
        end
        m_grant = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
    endtask

    task automatic compare_model(input string tag);
        check({tag, "_grant"}, src_grant, m_grant);
        check({tag, "_put"}, ep_data_put, m_put);
        check({tag, "_done"}, ep_data_done, m_done);
        check({tag, "_busy"}, busy, m_owner >= 0);
        check({tag, "_perr"}, put_err, m_perr);
        check({tag, "_terr"}, timeout_err, m_terr);
        if (m_put != 0) check({tag, "_data"}, ep_data, m_data);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        src_req = '0; src_put = '0; src_last = '0; src_data = '0; ep_data_free = 4'hF;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    function automatic int oh_idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [3:0] req, put, last, free;
        logic [7:0] byt;
        logic [3:0] e_grant, e_put, e_done;
        logic [7:0] e_data;
        logic       e_busy, e_perr;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] req, put, last, free, input logic [7:0] byt,
                                input logic [3:0] eg, ep, ed, input logic [7:0] edat,
                                input logic eb, epe);
        vec_t v;
        v.req = req; v.put = put; v.last = last; v.free = free; v.byt = byt;
        v.e_grant = eg; v.e_put = ep; v.e_done = ed; v.e_data = edat; v.e_busy = eb; v.e_perr = epe;
        return v;
    endfunction

    vec_t vecs[15];

    initial begin
        int gidx[5], gtime[5];
        int gcount, cyc, sent, seen, ndone, bad, gcyc, dcyc;
        logic [3:0] prev, g, done_seen;
        bit dropped;

        src_req = '0; src_put = '0; src_last = '0; src_data = '0; ep_data_free = 4'hF;

        // src0 3-byte packet, src2 stalled by a full buffer, src3 zero-length, stray put
        vecs[0]  = mk(4'b0101, 4'b0000, 4'b0000, 4'hF, 8'h00, 4'b0001, 4'b0000, 4'b0000, 8'h00, 1, 0);
        vecs[1]  = mk(4'b0101, 4'b0001, 4'b0000, 4'hF, 8'hA1, 4'b0001, 4'b0001, 4'b0000, 8'hA1, 1, 0);
        vecs[2]  = mk(4'b0101, 4'b0001, 4'b0000, 4'hF, 8'hA2, 4'b0001, 4'b0001, 4'b0000, 8'hA2, 1, 0);
        vecs[3]  = mk(4'b0101, 4'b0001, 4'b0001, 4'hF, 8'hA3, 4'b0000, 4'b0001, 4'b0001, 8'hA3, 0, 0);
        vecs[4]  = mk(4'b0101, 4'b0000, 4'b0000, 4'hF, 8'h00, 4'b0000, 4'b0000, 4'b0000, 8'h00, 0, 0);
        vecs[5]  = mk(4'b0101, 4'b0000, 4'b0000, 4'hF, 8'h00, 4'b0100, 4'b0000, 4'b0000, 8'h00, 1, 0);
        vecs[6]  = mk(4'b0101, 4'b0100, 4'b0000, 4'hB, 8'hB1, 4'b0100, 4'b0000, 4'b0000, 8'h00, 1, 0);
        vecs[7]  = mk(4'b0101, 4'b0100, 4'b0000, 4'hB, 8'hB2, 4'b0100, 4'b0000, 4'b0000, 8'h00, 1, 0);
        vecs[8]  = mk(4'b0101, 4'b0100, 4'b0100, 4'hF, 8'hB3, 4'b0000, 4'b0100, 4'b0100, 8'hB3, 0, 0);
        vecs[9]  = mk(4'b0000, 4'b0000, 4'b0000, 4'hF, 8'h00, 4'b0000, 4'b0000, 4'b0000, 8'h00, 0, 0);
        vecs[10] = mk(4'b1000, 4'b0000, 4'b0000, 4'hF, 8'h00, 4'b1000, 4'b0000, 4'b0000, 8'h00, 1, 0);
        vecs[11] = mk(4'b0000, 4'b0000, 4'b0000, 4'hF, 8'h00, 4'b0000, 4'b0000, 4'b1000, 8'h00, 0, 0);
        vecs[12] = mk(4'b0000, 4'b0000, 4'b0000, 4'hF, 8'h00, 4'b0000, 4'b0000, 4'b0000, 8'h00, 0, 0);
        vecs[13] = mk(4'b0000, 4'b0010, 4'b0000, 4'hF, 8'h5A, 4'b0000, 4'b0000, 4'b0000, 8'h00, 0, 1);
        vecs[14] = mk(4'b0000, 4'b0000, 4'b0000, 4'hF, 8'h00, 4'b0000, 4'b0000, 4'b0000, 8'h00, 0, 1);

        do_reset();
        check("rst_grant", src_grant, 0);
        check("rst_put", ep_data_put, 0);
        check("rst_done", ep_data_done, 0);
        check("rst_data", ep_data, 0);
        check("rst_busy", busy, 0);
        check("rst_perr", put_err, 0);
        check("rst_terr", timeout_err, 0);

        for (int r = 0; r < 15; r++) begin
            src_req = vecs[r].req; src_put = vecs[r].put; src_last = vecs[r].last;
            ep_data_free = vecs[r].free;
            for (int i = 0; i < 4; i++)
                src_data[8*i +: 8] = vecs[r].put[i] ? vecs[r].byt : 8'($urandom);
            @(negedge clk);
            check($sformatf("vec%0d_grant", r), src_grant, vecs[r].e_grant);
            check($sformatf("vec%0d_put", r), ep_data_put, vecs[r].e_put);
            check($sformatf("vec%0d_done", r), ep_data_done, vecs[r].e_done);
            check($sformatf("vec%0d_busy", r), busy, vecs[r].e_busy);
            check($sformatf("vec%0d_perr", r), put_err, vecs[r].e_perr);
            check($sformatf("vec%0d_terr", r), timeout_err, 0);
            if (vecs[r].e_put != 0) check($sformatf("vec%0d_data", r), ep_data, vecs[r].e_data);
        end

        // Round robin: all request; each source puts a 1-byte packet one cycle after seeing its grant
        do_reset();
        src_req = 4'hF; gcount = 0; prev = '0;
        for (cyc = 1; cyc <= 40 && gcount < 5; cyc++) begin
            @(negedge clk);
            g = src_grant;
            if (g != 0 && prev == 0) begin
                check("rr_onehot", $onehot(g), 1);
                gidx[gcount] = oh_idx(g); gtime[gcount] = cyc; gcount++;
                src_put = '0; src_last = '0;
            end else if (g != 0 && prev == g) begin
                src_put = g; src_last = g; src_data = $urandom;
            end else begin
                src_put = '0; src_last = '0;
            end
            prev = g;
        end
        check("rr_grants", gcount, 5);
        for (int i = 0; i < 5; i++) begin
            if (i < gcount) begin
                check($sformatf("rr_order%0d", i), gidx[i], i % 4);
                if (i > 0) check($sformatf("rr_space%0d", i), gtime[i] - gtime[i-1], 4);
            end
        end
        check("rr_perr", put_err, 0);

        // src1 streams bytes with no src_last until the packet fills
        do_reset();
        src_req = 4'b0010; sent = 0; seen = 0; ndone = 0; bad = 0; dropped = 1'b0;
        for (int c = 0; c < 60 && !dropped; c++) begin
            @(negedge clk);
            if (ep_data_put != 0) begin
                if (ep_data_put !== 4'b0010 || ep_data !== 8'(64 + seen)) bad++;
                seen++;
            end
            if (ep_data_done != 0) ndone++;
            if (src_grant[1]) begin
                src_put = 4'b0010; src_data[15:8] = 8'(64 + sent); sent++;
            end else begin
                src_put = '0;
                if (sent > 0) dropped = 1'b1;
            end
        end
        check("full_released", dropped, 1);
        check("full_sent", sent, MAXP);
        check("full_puts", seen, MAXP);
        check("full_done", ndone, 0);
        check("full_data", bad, 0);
        check("full_perr_pre", put_err, 0);
        src_req = '0; src_put = 4'b0010; src_data[15:8] = 8'hEE;
        @(negedge clk);
        src_put = '0;
        check("full_perr_33", put_err, 1);
        check("full_put_33", ep_data_put, 0);

        // Reset in the middle of a packet
        do_reset();
        src_req = 4'b0001;
        @(negedge clk);
        src_put = 4'b0001; src_data[7:0] = 8'h77;
        @(posedge clk);
        #2;
        check("mid_put", ep_data_put, 4'b0001);
        reset_n = 1'b0;
        #1;
        check("mid_rst_grant", src_grant, 0);
        check("mid_rst_put", ep_data_put, 0);
        check("mid_rst_done", ep_data_done, 0);
        check("mid_rst_data", ep_data, 0);
        check("mid_rst_busy", busy, 0);
        src_put = '0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("mid_regrant", src_grant, 4'b0001);
        check("mid_nodone", ep_data_done, 0);
        check("mid_noput", ep_data_put, 0);

        // Idle grant
        do_reset();
        src_req = 4'b0001;
`ifdef USB_IN_ARB_TIMEOUT_EN
        gcyc = -1; dcyc = -1;
        for (int c = 1; c <= 30 && dcyc < 0; c++) begin
            @(negedge clk);
            if (gcyc < 0 && src_grant[0]) gcyc = c;
            if (ep_data_done != 0) begin
                dcyc = c;
                check("to_done_vec", ep_data_done, 4'b0001);
            end
        end
        check("to_latency", dcyc - gcyc, TO);
        check("to_err_set", timeout_err, 1);
        #2 reset_n = 1'b0;
        #1;
        check("to_rst_err", timeout_err, 0);
        check("to_rst_grant", src_grant, 0);
        check("to_rst_done", ep_data_done, 0);
        @(negedge clk);
        reset_n = 1'b1;
`else
        gcyc = 0; dcyc = 0; done_seen = '0;
        repeat (20) begin
            @(negedge clk);
            done_seen = done_seen | ep_data_done;
        end
        check("hold_grant", src_grant, 4'b0001);
        check("hold_nodone", done_seen, 0);
        check("hold_terr", timeout_err, 0);
`endif

        // Randomised traffic against the reference model
        for (int ep = 0; ep < 4; ep++) begin
            do_reset();
            for (int c = 0; c < 250; c++) begin
                logic [3:0]  rq, pt, ls, fr;
                logic [31:0] dw;
                for (int i = 0; i < 4; i++) begin
                    rq[i] = ($urandom_range(0, 99) < 80);
                    fr[i] = (ep == 0) ? 1'b1 : ($urandom_range(0, 99) < 85);
                end
                pt = '0; ls = 4'($urandom);
                if (m_owner >= 0) begin
                    if (ep == 3) rq[m_owner] = 1'b1;
                    if ($urandom_range(0, 99) < ((ep == 3) ? 90 : 65)) begin
                        pt[m_owner] = 1'b1;
                        ls[m_owner] = ($urandom_range(0, 99) < ((ep == 3) ? 2 : 25));
                    end
                end
                if ($urandom_range(0, 199) == 0) pt[$urandom_range(0, 3)] = 1'b1;
                dw = $urandom;
                src_req = rq; src_put = pt; src_last = ls; ep_data_free = fr; src_data = dw;
                model_step(rq, pt, ls, fr, dw);
                @(negedge clk);
                compare_model("rnd");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/usb_fs_in_arb.md
USB_FS_IN_ARB -- requirements
Module: usb_fs_in_arb

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, number of endpoint data sources; source i feeds IN endpoint i.
REQ-002 SHALL have parameter MAX_IN_PACKET_SIZE, default 32, maximum bytes per packet.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, idle-grant limit, used only under USB_IN_ARB_TIMEOUT_EN.
REQ-004 SHALL have ports: clk  in  1  sole clock, rising edge; reset_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports: src_req  in  NUM_SRC  source i has a packet to load; src_put  in  NUM_SRC  byte strobe; src_data  in  8*NUM_SRC  byte of source i at bits [8i+7:8i]; src_last  in  NUM_SRC  qualifies src_put as final byte.
REQ-006 SHALL have ports: src_grant  out  NUM_SRC  one-hot grant; ep_data_free  in  NUM_SRC  endpoint buffer free, from IN protocol engine.
REQ-007 SHALL have ports: ep_data_put  out  NUM_SRC  one-hot put to engine; ep_data  out  8  byte to engine; ep_data_done  out  NUM_SRC  one-hot packet-done pulse.
REQ-008 SHALL have ports: busy  out  1  grant active; put_err  out  1  sticky protocol error; timeout_err  out  1  sticky timeout flag.

Function
REQ-009 SHALL implement states IDLE, GRANT, RELEASE.
REQ-010 IDLE: eligible = src_req & ep_data_free; if nonzero, SHALL select first eligible index searching upward from last_winner+1 modulo NUM_SRC, assert src_grant[k] on next edge, enter GRANT.
REQ-011 Accepted byte SHALL be src_put[k] & src_grant[k] & ep_data_free[k] in GRANT.
REQ-012 Each accepted byte SHALL appear as ep_data_put[k]=1, ep_data=src_data[k] exactly one cycle later (registered, latency 1); ep_data_put SHALL be 0 otherwise.
REQ-013 A byte counter (width clog2(MAX_IN_PACKET_SIZE)+1) SHALL clear on grant and increment per accepted byte.
REQ-014 Accepted byte with src_last[k]: ep_data_done[k] SHALL pulse in the same cycle as that byte's ep_data_put[k]; enter RELEASE.
REQ-015 Accepted byte making count equal MAX_IN_PACKET_SIZE without src_last: no done pulse (engine self-terminates on full); enter RELEASE.
REQ-016 src_last and count reaching MAX on same byte: exactly one ep_data_done[k] pulse.
REQ-017 src_req[k] deasserted in GRANT with no byte accepted that cycle: ep_data_done[k] SHALL pulse next cycle (short/zero-length packet); enter RELEASE.
REQ-018 RELEASE SHALL last one cycle with src_grant=0, set last_winner=k, return to IDLE; no grant issued in RELEASE.
REQ-019 src_put[j] for any j not granted SHALL be ignored and set put_err; put_err clears only on reset.
REQ-020 busy SHALL equal (state==GRANT).
REQ-021 At most one bit of src_grant, ep_data_put, ep_data_done SHALL be high in any cycle.

Reset
REQ-022 reset_n low SHALL asynchronously force state IDLE, all outputs 0, counters 0, last_winner=NUM_SRC-1 (source 0 wins first).
REQ-023 Reset mid-packet SHALL abandon the packet with no done pulse; the first edge after reset_n rises SHALL behave as IDLE.

Configuration
REQ-024 Macro USB_IN_ARB_TIMEOUT_EN defined: idle counter clears on grant and each accepted byte, increments otherwise in GRANT; reaching TIMEOUT_CYCLES SHALL pulse ep_data_done[k], set timeout_err, enter RELEASE.
REQ-025 Macro undefined: no idle counter, grant held indefinitely, timeout_err tied 0.

Verification
REQ-026 Reset release, src_req=4'b0101, all free -> grant src0 first; after src0 sends 3 bytes last on 3rd -> done[0] with 3rd put, RELEASE, then grant src2.
REQ-027 All 4 requesting continuously, 1-byte packets -> grant order 0,1,2,3,0; each grant-to-grant spacing = 4 cycles (grant, byte, release, idle-select).
REQ-028 Src1 sends 32 bytes, no src_last -> 32 ep_data_put[1] pulses, zero done pulses, release after 32nd byte; 33rd put raises put_err.
REQ-029 Src3 granted, drops src_req with 0 bytes -> single ep_data_done[3] pulse, no ep_data_put.
REQ-030 Src2 granted, ep_data_free[2] low during 2 puts -> those bytes not forwarded, counter unchanged.
REQ-031 With USB_IN_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, granted src idles -> done pulse after 8 cycles, timeout_err=1; reset_n pulse mid-grant -> all outputs 0, timeout_err 0.
